fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 19 +
 rtl/fetch_predecode.sv | 21 ++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: state encodings,
// opcode constants, default bubble word and offset sign-extension helper.
package fetch_unit_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  localparam logic [5:0] OP_J = 6'b000001;

  localparam logic [DATA_W-1:0] NOP_DEFAULT = 32'd0;

  function automatic logic signed [DATA_W-1:0] sext26(input logic [25:0] off);
    return {{(DATA_W-26){off[25]}}, off};
  endfunction

endpackage

// File: rtl/fetch_predecode.sv
// J-opcode detector and PC-relative jump target adder for the fetch stage.
// Only built when FETCH_JUMP_PREDECODE_EN is defined.
`ifdef FETCH_JUMP_PREDECODE_EN
module fetch_predecode
  import fetch_unit_pkg::*;
(
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] instr,
  output logic              is_j,
  output logic [DATA_W-1:0] target
);

  logic signed [DATA_W-1:0] offset;

  assign offset = sext26(instr[25:0]);
  assign is_j   = (instr[31:26] == OP_J);
  // Target is relative to the next sequential PC; wraps modulo 2^32.
  assign target = pc + 32'd1 + $unsigned(offset);

endmodule
`endif

// File: rtl/fetch_unit.sv
// Instruction fetch stage with IDLE/RUN/STALL control and an IF/ID register.
// Optional jump predecode in the fetch stage: define FETCH_JUMP_PREDECODE_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] NOP_WORD = NOP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc_plus1,
  output logic        if_id_valid,
  output logic [1:0]  state,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_p0, pc_n;
  logic [1:0]  st, st_n;
  logic [31:0] instr_p1, instr_n;
  logic [31:0] pcp1_p1, pcp1_n;
  logic        vld_p1, vld_n;
  logic [31:0] cnt, cnt_n;
  logic [31:0] pc_plus1;
  logic        fetch;

  assign pc_plus1 = pc_p0 + 32'd1;

`ifdef FETCH_JUMP_PREDECODE_EN
  logic        pd_is_j;
  logic [31:0] pd_target;

  fetch_predecode u_predecode (
    .pc     (pc_p0),
    .instr  (imem_instr),
    .is_j   (pd_is_j),
    .target (pd_target)
  );
`endif

  always_comb begin
    pc_n    = pc_p0;
    st_n    = st;
    instr_n = instr_p1;
    pcp1_n  = pcp1_p1;
    vld_n   = vld_p1;
    cnt_n   = cnt;
    fetch   = 1'b0;
    case (st)
      ST_IDLE: begin
        if (start) begin
          if (stall) st_n = ST_STALL;
          else       fetch = 1'b1;
        end
      end
      ST_RUN, ST_STALL: begin
        // Redirect outranks stall so a taken branch is never lost behind a hold.
        if (redirect_valid) begin
          st_n    = ST_RUN;
          pc_n    = redirect_pc;
          instr_n = NOP_WORD;
          vld_n   = 1'b0;
        end else if (stall) begin
          st_n = ST_STALL;
`ifdef FETCH_JUMP_PREDECODE_EN
        end else if (pd_is_j) begin
          st_n    = ST_RUN;
          pc_n    = pd_target;
          instr_n = NOP_WORD;
          vld_n   = 1'b0;
          cnt_n   = cnt + 32'd1;
`endif
        end else begin
          fetch = 1'b1;
        end
      end
      default: st_n = ST_IDLE;
    endcase
    if (fetch) begin
      st_n    = ST_RUN;
      pc_n    = pc_plus1;
      instr_n = imem_instr;
      pcp1_n  = pc_plus1;
      vld_n   = 1'b1;
      cnt_n   = cnt + 32'd1;
    end
  end

  // IF/ID stage boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0    <= RESET_PC;
      st       <= ST_IDLE;
      instr_p1 <= NOP_WORD;
      pcp1_p1  <= 32'd0;
      vld_p1   <= 1'b0;
      cnt      <= 32'd0;
    end else begin
      pc_p0    <= pc_n;
      st       <= st_n;
      instr_p1 <= instr_n;
      pcp1_p1  <= pcp1_n;
      vld_p1   <= vld_n;
      cnt      <= cnt_n;
    end
  end

  assign imem_pc        = pc_p0;
  assign if_id_instr    = instr_p1;
  assign if_id_pc_plus1 = pcp1_p1;
  assign if_id_valid    = vld_p1;
  assign state          = st;
  assign fetch_count    = cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a reference model pushes expected IF state
// into a scoreboard queue each cycle; results are popped and asserted after the edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, start, stall, redirect_valid;
  logic [31:0] redirect_pc, imem_pc, imem_instr;
  logic [31:0] if_id_instr, if_id_pc_plus1, fetch_count;
  logic        if_id_valid;
  logic [1:0]  state;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcp1;
    logic [31:0] cnt;
    logic [1:0]  st;
    logic        vld;
  } exp_t;

  exp_t sb[$];
  exp_t m;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .if_id_valid    (if_id_valid),
    .state          (state),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  // LI-style words everywhere, except a J with offset -3 at address 50.
  function automatic logic [31:0] imem_f(input logic [31:0] a);
    if (a == 32'd50) return {6'b000001, 26'h3FFFFFD};
    return {6'b001111, 5'd3, 21'(a ^ 32'h155)};
  endfunction

  always_comb imem_instr = imem_f(imem_pc);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_fetch();
    m.instr = imem_f(m.pc);
    m.pcp1  = m.pc + 32'd1;
    m.pc    = m.pc + 32'd1;
    m.vld   = 1'b1;
    m.cnt   = m.cnt + 32'd1;
    m.st    = 2'd1;
  endtask

  task automatic model_update(input logic r, input logic s, input logic h,
                              input logic rv, input logic [31:0] rp);
    logic [31:0] w;
    if (r) begin
      m.pc = 32'd0; m.st = 2'd0; m.instr = 32'd0; m.pcp1 = 32'd0; m.vld = 1'b0; m.cnt = 32'd0;
    end else if (m.st == 2'd0) begin
      if (s && h) m.st = 2'd2;
      else if (s) model_fetch();
    end else if (rv) begin
      m.st = 2'd1; m.pc = rp; m.instr = 32'd0; m.vld = 1'b0;
    end else if (h) begin
      m.st = 2'd2;
    end else begin
      w = imem_f(m.pc);
`ifdef FETCH_JUMP_PREDECODE_EN
      if (w[31:26] == 6'b000001) begin
        m.pc = m.pc + 32'd1 + {{6{w[25]}}, w[25:0]};
        m.instr = 32'd0; m.vld = 1'b0; m.cnt = m.cnt + 32'd1; m.st = 2'd1;
      end else model_fetch();
`else
      model_fetch();
`endif
    end
  endtask

  task automatic step(input logic s, input logic h, input logic rv,
                      input logic [31:0] rp, input logic r = 1'b0);
    exp_t e;
    rst = r; start = s; stall = h; redirect_valid = rv; redirect_pc = rp;
    model_update(r, s, h, rv, rp);
    sb.push_back(m);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("sb_pc",    imem_pc,        e.pc);
    chk("sb_instr", if_id_instr,    e.instr);
    chk("sb_pcp1",  if_id_pc_plus1, e.pcp1);
    chk("sb_cnt",   fetch_count,    e.cnt);
    chk("sb_state", {30'd0, state}, {30'd0, e.st});
    chk("sb_valid", {31'd0, if_id_valid}, {31'd0, e.vld});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    m = '{pc: 32'd0, instr: 32'd0, pcp1: 32'd0, cnt: 32'd0, st: 2'd0, vld: 1'b0};

    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("idle_pc",    imem_pc, 32'd0);
    chk("idle_state", {30'd0, state}, 32'd0);
    chk("idle_valid", {31'd0, if_id_valid}, 32'd0);
    chk("idle_count", fetch_count, 32'd0);

    step(1, 0, 0, 0);
    chk("run0_instr", if_id_instr, imem_f(32'd0));
    chk("run0_pcp1",  if_id_pc_plus1, 32'd1);
    step(0, 0, 0, 0);
    chk("run1_instr", if_id_instr, imem_f(32'd1));
    chk("run1_pcp1",  if_id_pc_plus1, 32'd2);
    step(0, 0, 0, 0);
    chk("run2_instr", if_id_instr, imem_f(32'd2));
    chk("run2_pcp1",  if_id_pc_plus1, 32'd3);
    chk("run2_count", fetch_count, 32'd3);

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("pre_stall_pc", imem_pc, 32'd5);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 0, 0);
      chk("stall_pc",    imem_pc, 32'd5);
      chk("stall_state", {30'd0, state}, 32'd2);
      chk("stall_instr", if_id_instr, imem_f(32'd4));
    end
    step(0, 0, 0, 0);
    chk("release_pc",    imem_pc, 32'd6);
    chk("release_instr", if_id_instr, imem_f(32'd5));

    step(0, 0, 1, 32'd42);
    chk("redir42_pc", imem_pc, 32'd42);
    step(0, 1, 1, 32'd43);
    chk("redir_stall_pc",    imem_pc, 32'd43);
    chk("redir_stall_instr", if_id_instr, 32'd0);
    chk("redir_stall_valid", {31'd0, if_id_valid}, 32'd0);
    chk("redir_stall_state", {30'd0, state}, 32'd1);

    step(0, 0, 1, 32'hFFFF_FFFF);
    step(0, 0, 0, 0);
    chk("wrap_pc",   imem_pc, 32'd0);
    chk("wrap_pcp1", if_id_pc_plus1, 32'd0);

    step(0, 0, 1, 32'd50);
    step(0, 0, 0, 0);
`ifdef FETCH_JUMP_PREDECODE_EN
    chk("jump_pc",    imem_pc, 32'd48);
    chk("jump_valid", {31'd0, if_id_valid}, 32'd0);
`else
    chk("jump_pc",    imem_pc, 32'd51);
    chk("jump_valid", {31'd0, if_id_valid}, 32'd1);
`endif

    step(0, 1, 0, 0);
    step(1, 1, 1, 32'd7, 1);
    chk("rst_stall_state", {30'd0, state}, 32'd0);
    chk("rst_stall_count", fetch_count, 32'd0);
    step(0, 0, 1, 32'd9);
    chk("idle_redir_pc", imem_pc, 32'd0);
    step(1, 1, 0, 0);
    chk("start_stall_state", {30'd0, state}, 32'd2);
    chk("start_stall_pc",    imem_pc, 32'd0);
    step(0, 0, 0, 0);
    chk("unstall_instr", if_id_instr, imem_f(32'd0));
    chk("unstall_count", fetch_count, 32'd1);
    step(0, 0, 0, 0);
    step(1, 0, 1, 32'd3, 1);
    chk("rst_run_pc",    imem_pc, 32'd0);
    chk("rst_run_count", fetch_count, 32'd0);
    chk("rst_run_valid", {31'd0, if_id_valid}, 32'd0);
    step(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
